// File: rtl/definitions.sv
// Shared constants and entry layout for the instruction fetch stage.
package definitions;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer: synchronous FIFO with flush and occupancy count.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [PW:0]      o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [PW:0]   LP_FULL = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   LP_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] LP_STEP = PW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full buffer is only taken when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + LP_STEP;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + LP_STEP;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LP_ONE;
                2'b01:   r_count <= r_count - LP_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_rst && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == LP_FULL);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC ownership, credit-limited pipelined IMEM requests,
// prefetch buffering and redirect handling with stale-response discard.
module fetch_unit
    import definitions::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_Req,
    output logic [31:0] IMEM_Addr,
    input  logic        IMEM_Ready,
    input  logic        IMEM_Valid,
    input  logic [31:0] IMEM_Data,
    input  logic        PC_Redirect_En_E,
    input  logic [31:0] PC_Target_E,
    input  logic        Stall_D,
    output logic        Valid_D,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC_Plus_4_D
);

    localparam int unsigned   PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW+1:0] LP_DEPTH = (PW + 2)'(FIFO_DEPTH);
    localparam logic [PW:0]   LP_ONE   = (PW + 1)'(1);
    localparam logic [PW-1:0] LP_STEP  = PW'(1);

    logic [31:0]  r_fetch_pc;
    logic [PW:0]  r_outstanding;
    logic [PW:0]  r_discard;
    logic [31:0]  r_pcq [FIFO_DEPTH];
    logic [PW-1:0] r_pcq_wr;
    logic [PW-1:0] r_pcq_rd;

    logic         w_credit;
    logic         w_accept;
    logic         w_resp;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic [PW:0]  w_count;
    logic [PW:0]  w_outstanding_nxt;
    fetch_entry_t w_head;
    fetch_entry_t w_push_entry;
    logic         w_unused_tgt;

    assign w_unused_tgt = ^PC_Target_E[1:0];

    // Credit uses registered occupancy only, keeping Stall_D/IMEM_Valid off the request path.
    assign w_credit  = ({1'b0, w_count} + {1'b0, r_outstanding}) < LP_DEPTH;
    assign IMEM_Req  = !RST && !PC_Redirect_En_E && w_credit;
    assign IMEM_Addr = r_fetch_pc;

    assign w_accept     = IMEM_Req && IMEM_Ready;
    assign w_resp       = IMEM_Valid && (r_outstanding != '0);
    assign w_push       = w_resp && !PC_Redirect_En_E && (r_discard == '0);
    assign w_pop        = !w_empty && !Stall_D && !PC_Redirect_En_E;
    assign w_push_entry = '{pc: r_pcq[r_pcq_rd], instr: IMEM_Data};

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_accept && !w_resp)      w_outstanding_nxt = r_outstanding + LP_ONE;
        else if (!w_accept && w_resp) w_outstanding_nxt = r_outstanding - LP_ONE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (w_accept) r_pcq_wr <= r_pcq_wr + LP_STEP;
            if (w_resp)   r_pcq_rd <= r_pcq_rd + LP_STEP;
            if (PC_Redirect_En_E) begin
                r_fetch_pc <= {PC_Target_E[31:2], 2'b00};
                r_discard  <= w_outstanding_nxt;
            end else begin
                if (w_accept)                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_resp && r_discard != '0)   r_discard  <= r_discard - LP_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept && !RST) r_pcq[r_pcq_wr] <= r_fetch_pc;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_flush (PC_Redirect_En_E),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign Valid_D     = !w_empty;
    assign Instr_D     = Valid_D ? w_head.instr : NOP_INSTR;
    assign PC_D        = Valid_D ? w_head.pc : RESET_PC;
    assign PC_Plus_4_D = PC_D + 32'd4;

    a_no_spurious_resp: assert property (@(posedge CLK) disable iff (RST)
        !(IMEM_Valid && r_outstanding == '0));

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based model of the fetch stage.
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        rst_i = 1'b1;
    logic        ready_i = 1'b0;
    logic        mvalid_i = 1'b0;
    logic [31:0] mdata_i = '0;
    logic        redir_i = 1'b0;
    logic [31:0] tgt_i = '0;
    logic        stall_i = 1'b0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc4_d;

    fetch_unit #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK              (CLK),
        .RST              (rst_i),
        .IMEM_Req         (imem_req),
        .IMEM_Addr        (imem_addr),
        .IMEM_Ready       (ready_i),
        .IMEM_Valid       (mvalid_i),
        .IMEM_Data        (mdata_i),
        .PC_Redirect_En_E (redir_i),
        .PC_Target_E      (tgt_i),
        .Stall_D          (stall_i),
        .Valid_D          (valid_d),
        .Instr_D          (instr_d),
        .PC_D             (pc_d),
        .PC_Plus_4_D      (pc4_d)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] pc; bit stale; }          out_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] data; int due; }          mem_t;

    out_t        oq[$];
    ent_t        fq[$];
    mem_t        mq[$];
    logic [31:0] m_fpc = RPC;
    bit          model_live = 0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    int          ready_pct = 100;
    int          stall_pct = 0;
    int          redir_pct = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          force_rst = 1;
    bit          force_redir = 0;
    logic [31:0] force_tgt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        bit   req, acc, pop;
        out_t o;
        int   lat;
        if (rst_i) begin
            oq.delete(); fq.delete(); mq.delete();
            m_fpc = RPC;
            model_live = 1;
            return;
        end
        if (!model_live) return;
        req = !redir_i && (fq.size() + oq.size() < DEPTH);
        acc = req && ready_i;
        pop = (fq.size() > 0) && !stall_i && !redir_i;
        if (pop) void'(fq.pop_front());
        if (mvalid_i) begin
            o = oq.pop_front();
            void'(mq.pop_front());
            if (!o.stale && !redir_i) fq.push_back('{instr: mdata_i, pc: o.pc});
        end
        if (acc) begin
            oq.push_back('{pc: m_fpc, stale: 0});
            lat = int'($urandom_range(lat_max, lat_min));
            mq.push_back('{data: $urandom, due: cyc + lat});
            m_fpc = m_fpc + 32'd4;
        end
        if (redir_i) begin
            fq.delete();
            foreach (oq[i]) oq[i].stale = 1;
            m_fpc = {tgt_i[31:2], 2'b00};
        end
    endtask

    task automatic compare();
        bit exp_req;
        if (!model_live) return;
        exp_req = !rst_i && !redir_i && (fq.size() + oq.size() < DEPTH);
        chk("IMEM_Req", 32'(imem_req), 32'(exp_req));
        chk("IMEM_Addr", imem_addr, m_fpc);
        chk("Valid_D", 32'(valid_d), 32'(fq.size() > 0));
        if (fq.size() > 0) begin
            chk("Instr_D", instr_d, fq[0].instr);
            chk("PC_D", pc_d, fq[0].pc);
            chk("PC_Plus_4_D", pc4_d, fq[0].pc + 32'd4);
        end else begin
            chk("Instr_D_nop", instr_d, NOP);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        cyc++;
        #1;
        rst_i       = force_rst;
        redir_i     = force_redir || (int'($urandom_range(99)) < redir_pct);
        tgt_i       = force_redir ? force_tgt : $urandom;
        force_redir = 0;
        stall_i     = int'($urandom_range(99)) < stall_pct;
        ready_i     = int'($urandom_range(99)) < ready_pct;
        mvalid_i    = !rst_i && (mq.size() > 0) && (mq[0].due <= cyc);
        mdata_i     = mvalid_i ? mq[0].data : $urandom;
        @(negedge CLK);
        compare();
    endtask

    task automatic do_reset();
        force_rst = 1;
        step();
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", 32'(valid_d), 32'd0);
        chk("rst_instr", instr_d, 32'h0000_0013);
        chk("rst_pc", pc_d, RPC);
        chk("rst_pc4", pc4_d, RPC + 32'd4);
        force_rst = 0;
    endtask

    task automatic set_knobs(input int rdy, input int stl, input int rdr, input int lmin, input int lmax);
        ready_pct = rdy; stall_pct = stl; redir_pct = rdr; lat_min = lmin; lat_max = lmax;
    endtask

    initial begin
        // Stream start, stall backpressure and drain.
        set_knobs(100, 0, 0, 1, 1);
        do_reset();
        step(); chk("t1_c1_req", 32'(imem_req), 32'd1); chk("t1_c1_addr", imem_addr, 32'h0);
                chk("t1_c1_valid", 32'(valid_d), 32'd0);
        step(); chk("t1_c2_addr", imem_addr, 32'h4);
        step(); chk("t1_c3_addr", imem_addr, 32'h8); chk("t1_c3_valid", 32'(valid_d), 32'd1);
                chk("t1_c3_pc", pc_d, 32'h0); chk("t1_c3_pc4", pc4_d, 32'h4);
        step(); chk("t1_c4_pc", pc_d, 32'h4);
        step(); chk("t1_c5_pc", pc_d, 32'h8);
        stall_pct = 100;
        for (int n = 6; n <= 10; n++) begin
            step();
            chk("t1_stall_pc", pc_d, 32'hC);
            if (n == 7) chk("t1_stall_req_hi", 32'(imem_req), 32'd1);
            if (n >= 8) chk("t1_stall_req_lo", 32'(imem_req), 32'd0);
        end
        stall_pct = 0;
        for (int n = 11; n <= 16; n++) begin
            step();
            chk("t1_drain_valid", 32'(valid_d), 32'd1);
            chk("t1_drain_pc", pc_d, 32'(32'hC + 4 * (n - 11)));
        end

        // Redirect with two responses outstanding.
        set_knobs(100, 0, 0, 3, 3);
        do_reset();
        step(); step();
        force_redir = 1; force_tgt = 32'h0000_0103;
        step(); chk("t3_redir_req", 32'(imem_req), 32'd0);
        step(); chk("t3_addr", imem_addr, 32'h100); chk("t3_req", 32'(imem_req), 32'd1);
        for (int n = 4; n <= 7; n++) begin
            if (n > 4) step();
            chk("t3_bubble", 32'(valid_d), 32'd0);
        end
        step(); chk("t3_valid", 32'(valid_d), 32'd1); chk("t3_pc", pc_d, 32'h100);
                chk("t3_pc4", pc4_d, 32'h104);

        // Redirect coinciding with a response while decode stalls.
        set_knobs(100, 0, 0, 1, 1);
        do_reset();
        repeat (4) step();
        stall_pct = 1000; force_redir = 1; force_tgt = 32'h0000_0040;
        step(); chk("t4_redir_req", 32'(imem_req), 32'd0);
        stall_pct = 0;
        step(); chk("t4_valid", 32'(valid_d), 32'd0); chk("t4_instr", instr_d, 32'h0000_0013);
                chk("t4_addr", imem_addr, 32'h40); chk("t4_req", 32'(imem_req), 32'd1);
        step(); chk("t4_valid2", 32'(valid_d), 32'd0);
        step(); chk("t4_pc", pc_d, 32'h40); chk("t4_valid3", 32'(valid_d), 32'd1);

        // Fetch PC wrap at 2^32.
        set_knobs(100, 0, 0, 1, 1);
        do_reset();
        step();
        force_redir = 1; force_tgt = 32'hFFFF_FFF8;
        step();
        step(); chk("t5_addr_fff8", imem_addr, 32'hFFFF_FFF8);
        step(); chk("t5_addr_fffc", imem_addr, 32'hFFFF_FFFC);
        step(); chk("t5_addr_wrap", imem_addr, 32'h0);
        step(); chk("t5_pc", pc_d, 32'hFFFF_FFFC); chk("t5_pc4", pc4_d, 32'h0);
        step(); chk("t5_pc_wrap", pc_d, 32'h0); chk("t5_pc4_wrap", pc4_d, 32'h4);

        // Reset with a full buffer.
        set_knobs(100, 100, 0, 1, 1);
        do_reset();
        repeat (8) step();
        chk("t6_full_valid", 32'(valid_d), 32'd1); chk("t6_full_req", 32'(imem_req), 32'd0);
        chk("t6_full_pc", pc_d, 32'h0);
        do_reset();
        step(); chk("t6_restart_req", 32'(imem_req), 32'd1); chk("t6_restart_addr", imem_addr, RPC);
                chk("t6_restart_valid", 32'(valid_d), 32'd0);

        // Randomized traffic under several memory/decode profiles.
        set_knobs(80, 25, 3, 1, 3);  do_reset(); repeat (1000) step();
        set_knobs(50, 50, 5, 1, 6);  do_reset(); repeat (1000) step();
        set_knobs(100, 10, 2, 1, 1); do_reset(); repeat (1000) step();
        set_knobs(90, 0, 0, 2, 2);   do_reset(); repeat (300) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I pipeline, sitting directly upstream of the decode stage. It owns the program counter, issues pipelined word requests to instruction memory over a ready/valid handshake, and buffers returned instructions in a small in-order prefetch FIFO. The FIFO head is presented to decode as `Instr_D`/`PC_D`/`PC_Plus_4_D`. Redirects from execute (taken branch, JAL, JALR) flush the buffer and drop in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `FIFO_DEPTH`, default 4: prefetch entries; power of two, ≥2; also caps outstanding requests.
- `CLK`  in  1  clock, all state on rising edge.
- `RST`  in  1  reset; one clock, synchronous, active-high.
- `IMEM_Req`  out  1  request valid.
- `IMEM_Addr`  out  32  word-aligned fetch address.
- `IMEM_Ready`  in  1  memory accepts the request this cycle.
- `IMEM_Valid`  in  1  response data valid; responses return in order, at least one cycle after acceptance.
- `IMEM_Data`  in  32  instruction word.
- `PC_Redirect_En_E`  in  1  redirect request from execute.
- `PC_Target_E`  in  32  redirect target; bits [1:0] ignored (treated as 00).
- `Stall_D`  in  1  decode holds; head not consumed.
- `Valid_D`  out  1  head entry valid.
- `Instr_D`  out  32  head instruction; `NOP_INSTR` when `!Valid_D`.
- `PC_D`  out  32  head PC.
- `PC_Plus_4_D`  out  32  `PC_D + 4`, modulo 2^32.

## Operation
- State: `Fetch_PC` (next address to request), FIFO of `{instr, pc}`, `Outstanding` counter (accepted, not yet returned), `Discard` counter (responses to drop).
- Issue: `IMEM_Req = !RST && !PC_Redirect_En_E && (Count + Outstanding < FIFO_DEPTH)`. The credit check uses registered values only, so there is no combinational path from `Stall_D` or `IMEM_Valid` to `IMEM_Req`. `IMEM_Addr = Fetch_PC`.
- Accept (`IMEM_Req && IMEM_Ready`): `Fetch_PC += 4` (wraps at 2^32), `Outstanding++`. The PC of each request is pushed into a side queue and paired with its response.
- Response (`IMEM_Valid`): `Outstanding--`. If `Discard > 0`, drop the response and decrement `Discard`. Otherwise push into the FIFO. The credit rule guarantees the FIFO never overflows. An `IMEM_Valid` with `Outstanding == 0` is a protocol error: ignore it and fire an assertion.
- Pop: when `Valid_D && !Stall_D`, the head is consumed.
- Redirect (`PC_Redirect_En_E`): highest priority. Flush the FIFO. Set `Fetch_PC = {PC_Target_E[31:2],2'b00}`. Set `Discard = Outstanding` after this cycle's accept/response accounting; a response arriving in the redirect cycle is itself dropped. No request is issued in the redirect cycle. Pop is suppressed.
- Simultaneous push and pop on the FIFO is legal in any state, including when full.
- Stall with redirect: redirect wins and the FIFO is still flushed.

## Timing
- Reset values: `IMEM_Req=0`, `IMEM_Addr=RESET_PC`, `Valid_D=0`, `Instr_D=NOP_INSTR`, `PC_D=RESET_PC`, `PC_Plus_4_D=RESET_PC+4`, all counters 0. Reset overrides redirect.
- First request is issued in the first cycle with `RST` low.
- Latency, accept to decode: accept at cycle t, response at t+k (k≥1), written at the edge ending t+k, `Valid_D=1` in cycle t+k+1.
- Throughput: with k=1, no stalls and `FIFO_DEPTH≥3`, one instruction per cycle.
- Redirect at cycle r: `Valid_D=0` in r+1. The target request is issued in r+1. The first target instruction reaches decode no earlier than r+3.
- Reset asserted mid-operation: all state is cleared. In-flight responses arriving after reset are not tracked, so the memory model is reset on the same `RST`.

## Structure
- The `definitions` package holds `NOP_INSTR = 32'h0000_0013` and the default reset PC constant.
- One sub-module: `fetch_fifo`, a parameterised synchronous FIFO (push/pop/flush, `Count`, full/empty) storing 64-bit `{pc, instr}` entries.
- The PC side queue and counters live in `fetch_unit`.

## Test plan
- Reset release, `IMEM_Ready=1`, k=1 -> requests to 0x0, 0x4, 0x8 on consecutive cycles. `Valid_D` first high in cycle 3 with `PC_D=0x0`, `PC_Plus_4_D=0x4`; then one instruction per cycle.
- `Stall_D` held 5 cycles -> head unchanged, `IMEM_Req` drops once `Count+Outstanding=4`. On release, 4 buffered instructions pop in order with no bubble.
- Redirect to 0x0000_0103 with 2 responses outstanding -> next `IMEM_Addr=0x100`. Both stale responses dropped; first `PC_D` after redirect is 0x100.
- Redirect coinciding with a response and `Stall_D=1` -> response dropped, FIFO empty next cycle, `Valid_D=0`, `Instr_D=0x0000_0013`.
- `Fetch_PC=0xFFFF_FFFC` -> next request address 0x0000_0000. `PC_Plus_4_D` for the head entry = 0x0.
- `RST` asserted mid-stream with full FIFO -> next cycle all outputs at reset values; fetch restarts at `RESET_PC`.
